// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM states, word packing constant
// and the opcode encodings carried in the upper field of each instruction word.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        CNT,
        DATA,
        CHK,
        RUN,
        ERROR
    } state_t;

    localparam int unsigned BYTES_PER_WORD = 3;

    localparam logic [4:0] OP_NOP  = 5'h00;
    localparam logic [4:0] OP_LDI  = 5'h01;
    localparam logic [4:0] OP_ADD  = 5'h02;
    localparam logic [4:0] OP_JMP  = 5'h10;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input, reload request and instruction-memory write port of the loader.
interface prog_loader_if #(
    parameter int CNTR_WIDTH    = 8,
    parameter int COMBINED_DATA = 24
);
    logic                     in_valid;
    logic [7:0]               in_data;
    logic                     in_ready;
    logic                     reload;
    logic                     wr_en;
    logic [CNTR_WIDTH-1:0]    wr_addr;
    logic [COMBINED_DATA-1:0] wr_data;
    logic                     core_rst_ext;
    logic                     done;
    logic                     err;

    modport slave (
        input  in_valid, in_data, reload,
        output in_ready, wr_en, wr_addr, wr_data, core_rst_ext, done, err
    );

    modport master (
        output in_valid, in_data, reload,
        input  in_ready, wr_en, wr_addr, wr_data, core_rst_ext, done, err
    );
endinterface

// File: rtl/prog_loader_word_assembler.sv
// Packs accepted bytes MSB-first into instruction words; word_done flags the last byte.
module word_assembler
    import prog_loader_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        byte_valid,
    input  logic [7:0]                  byte_in,
    output logic                        word_done,
    output logic [8*BYTES_PER_WORD-1:0] word
);
    localparam int unsigned HOLD_W   = 8 * (BYTES_PER_WORD - 1);
    localparam logic [1:0]  LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [1:0]        idx_q, idx_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    always_comb begin
        idx_d  = idx_q;
        hold_d = hold_q;
        if (clr) begin
            idx_d  = '0;
            hold_d = '0;
        end else if (byte_valid) begin
            hold_d = {hold_q[HOLD_W-9:0], byte_in};
            idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + 2'd1;
        end
    end

    // The final byte is used straight from the input so the word is ready the same cycle.
    assign word_done = byte_valid && !clr && (idx_q == LAST_IDX);
    assign word      = {hold_q, byte_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            hold_q <= '0;
        end else begin
            idx_q  <= idx_d;
            hold_q <= hold_d;
        end
    end
endmodule

// File: rtl/prog_loader.sv
// Loads a count-prefixed, checksummed byte stream into instruction memory and
// releases the core reset once the checksum matches.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CNTR_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 5,
    parameter int UNDEFINED     = 3,
    parameter int DATA_WIDTH    = 16,
    parameter int COMBINED_DATA = ADDR_WIDTH + UNDEFINED + DATA_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    prog_loader_if.slave bus
);
    state_t                   state_q, state_d;
    logic [7:0]               csum_q, csum_d;
    logic [CNTR_WIDTH-1:0]    words_left_q, words_left_d;
    logic [CNTR_WIDTH-1:0]    word_idx_q, word_idx_d;
    logic                     wr_en_q, wr_en_d;
    logic [CNTR_WIDTH-1:0]    wr_addr_q, wr_addr_d;
    logic [COMBINED_DATA-1:0] wr_data_q, wr_data_d;
    logic                     core_rst_q, core_rst_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    logic                        in_ready;
    logic                        accept;
    logic                        asm_done;
    logic [8*BYTES_PER_WORD-1:0] asm_word;

    assign in_ready = (state_q == CNT) || (state_q == DATA) || (state_q == CHK);
    // A byte arriving with reload is dropped, so it never reaches the assembler.
    assign accept   = bus.in_valid && in_ready && !bus.reload;

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (bus.reload),
        .byte_valid (accept && (state_q == DATA)),
        .byte_in    (bus.in_data),
        .word_done  (asm_done),
        .word       (asm_word)
    );

    always_comb begin
        state_d      = state_q;
        csum_d       = csum_q;
        words_left_d = words_left_q;
        word_idx_d   = word_idx_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        core_rst_d   = core_rst_q;
        done_d       = done_q;
        err_d        = err_q;
        if (bus.reload) begin
            state_d      = CNT;
            csum_d       = '0;
            words_left_d = '0;
            word_idx_d   = '0;
            core_rst_d   = 1'b0;
            done_d       = 1'b0;
            err_d        = 1'b0;
        end else if (accept) begin
            case (state_q)
                CNT: begin
                    csum_d       = csum_q ^ bus.in_data;
                    words_left_d = CNTR_WIDTH'(bus.in_data) - CNTR_WIDTH'(1);
                    state_d      = DATA;
                end
                DATA: begin
                    csum_d = csum_q ^ bus.in_data;
                    if (asm_done) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = word_idx_q;
                        wr_data_d  = COMBINED_DATA'(asm_word);
                        word_idx_d = word_idx_q + CNTR_WIDTH'(1);
                        if (words_left_q == '0) state_d = CHK;
                        else words_left_d = words_left_q - CNTR_WIDTH'(1);
                    end
                end
                CHK: begin
                    if (bus.in_data == csum_q) begin
                        state_d    = RUN;
                        core_rst_d = 1'b1;
                        done_d     = 1'b1;
                    end else begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= CNT;
            csum_q       <= '0;
            words_left_q <= '0;
            word_idx_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            core_rst_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            csum_q       <= csum_d;
            words_left_q <= words_left_d;
            word_idx_q   <= word_idx_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            core_rst_q   <= core_rst_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.core_rst_ext = core_rst_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued as bytes are sent
// and matched against every wr_en pulse.
module tb_prog_loader;
    logic clk = 1'b0;
    logic rst;

    prog_loader_if #(.CNTR_WIDTH(8), .COMBINED_DATA(24)) bif ();

    prog_loader #(.CNTR_WIDTH(8), .ADDR_WIDTH(5), .UNDEFINED(3), .DATA_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int unsigned wr_count = 0;
    logic [7:0]  last_addr = '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bif.wr_en === 1'b1) begin
            wr_count++;
            last_addr = bif.wr_addr;
            if (exp_addr_q.size() == 0) begin
                check_eq("unexpected_wr", 32'(bif.wr_addr), 32'hDEAD);
            end else begin
                check_eq("wr_addr", 32'(bif.wr_addr), exp_addr_q.pop_front());
                check_eq("wr_data", 32'(bif.wr_data), exp_data_q.pop_front());
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        bif.in_valid = 1'b1;
        bif.in_data  = b;
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
        bif.in_data  = $urandom_range(0, 255);
    endtask

    task automatic send_word(input logic [23:0] w, input int unsigned idx, inout logic [7:0] cs);
        exp_addr_q.push_back(32'(idx));
        exp_data_q.push_back(32'(w));
        for (int b = 2; b >= 0; b--) begin
            logic [7:0] bt;
            bt = w[8*b +: 8];
            cs ^= bt;
            send_byte(bt);
        end
    endtask

    task automatic load(input logic [7:0] n, input logic [23:0] words[$], input logic [7:0] flip);
        logic [7:0] cs;
        cs = n;
        send_byte(n);
        for (int i = 0; i < words.size(); i++) send_word(words[i], i, cs);
        send_byte(cs ^ flip);
    endtask

    task automatic do_reload();
        #1;
        bif.reload = 1'b1;
        @(posedge clk);
        #1;
        bif.reload = 1'b0;
        check_eq("rl_done", 32'(bif.done), 0);
        check_eq("rl_err", 32'(bif.err), 0);
        check_eq("rl_core_rst", 32'(bif.core_rst_ext), 0);
        check_eq("rl_in_ready", 32'(bif.in_ready), 1);
    endtask

    initial begin
        logic [23:0] ws[$];
        logic [7:0]  cs;
        int unsigned base;

        rst = 1'b1;
        bif.in_valid = 1'b0;
        bif.in_data  = '0;
        bif.reload   = 1'b0;
        #1;
        check_eq("rst_wr_en", 32'(bif.wr_en), 0);
        check_eq("rst_wr_addr", 32'(bif.wr_addr), 0);
        check_eq("rst_wr_data", 32'(bif.wr_data), 0);
        check_eq("rst_core", 32'(bif.core_rst_ext), 0);
        check_eq("rst_done", 32'(bif.done), 0);
        check_eq("rst_err", 32'(bif.err), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_eq("post_rst_ready", 32'(bif.in_ready), 1);

        // single word, checksum C6
        ws = '{24'hA12345};
        load(8'h01, ws, 8'h00);
        check_eq("s1_done", 32'(bif.done), 1);
        check_eq("s1_core", 32'(bif.core_rst_ext), 1);
        check_eq("s1_err", 32'(bif.err), 0);
        check_eq("s1_ready", 32'(bif.in_ready), 0);

        // byte presented in RUN is ignored
        base = wr_count;
        bif.in_valid = 1'b1;
        bif.in_data  = 8'h55;
        repeat (3) @(posedge clk);
        #1 bif.in_valid = 1'b0;
        @(negedge clk);
        check_eq("run_ign_wr", wr_count - base, 0);
        check_eq("run_ign_done", 32'(bif.done), 1);
        do_reload();

        ws = '{24'h000001, 24'h080005};
        load(8'h02, ws, 8'h00);
        check_eq("s2_done", 32'(bif.done), 1);
        check_eq("s2_core", 32'(bif.core_rst_ext), 1);
        do_reload();

        load(8'h02, ws, 8'hFF);
        check_eq("s3_err", 32'(bif.err), 1);
        check_eq("s3_core", 32'(bif.core_rst_ext), 0);
        check_eq("s3_ready", 32'(bif.in_ready), 0);
        check_eq("s3_done", 32'(bif.done), 0);
        do_reload();

        // N=0 means 256 words
        ws = {};
        for (int i = 0; i < 256; i++) ws.push_back(24'($urandom));
        base = wr_count;
        load(8'h00, ws, 8'h00);
        @(negedge clk);
        check_eq("s4_count", wr_count - base, 256);
        check_eq("s4_last_addr", 32'(last_addr), 32'hFF);
        check_eq("s4_done", 32'(bif.done), 1);
        do_reload();

        // reload coinciding with the third byte of word 1
        cs = 8'h02;
        send_byte(8'h02);
        send_word(24'h0A0B0C, 0, cs);
        send_byte(8'h11);
        send_byte(8'h22);
        base = wr_count;
        bif.in_valid = 1'b1;
        bif.in_data  = 8'h33;
        do_reload();
        bif.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("s5_no_wr", wr_count - base, 0);
        ws = '{24'h123456};
        load(8'h01, ws, 8'h00);
        check_eq("s5_done", 32'(bif.done), 1);
        check_eq("s5_core", 32'(bif.core_rst_ext), 1);
        do_reload();

        // asynchronous reset mid-DATA
        cs = 8'h03;
        send_byte(8'h03);
        send_word(24'h1F2E3D, 0, cs);
        send_word(24'h4C5B6A, 1, cs);
        send_byte(8'h77);
        @(negedge clk);
        check_eq("s6_pre_addr", 32'(bif.wr_addr), 1);
        #2 rst = 1'b1;
        #1;
        check_eq("s6_wr_en", 32'(bif.wr_en), 0);
        check_eq("s6_wr_addr", 32'(bif.wr_addr), 0);
        check_eq("s6_wr_data", 32'(bif.wr_data), 0);
        check_eq("s6_core", 32'(bif.core_rst_ext), 0);
        check_eq("s6_done", 32'(bif.done), 0);
        check_eq("s6_err", 32'(bif.err), 0);
        check_eq("s6_ready", 32'(bif.in_ready), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        ws = '{24'hFEDCBA};
        load(8'h01, ws, 8'h00);
        check_eq("s6_reload_done", 32'(bif.done), 1);

        repeat (2) @(negedge clk);
        check_eq("sb_empty", 32'(exp_addr_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
